// File: rtl/ex_div_stall_unit.sv
// EX-stage iterative radix-2 restoring divider that holds the pipeline through a stall request.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when the divisor is zero or |opa| < |opb|.
module ex_div_stall_unit #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STALL_W      = 6,
   parameter int unsigned EX_STALL_BIT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               div_start,
   input  logic               div_signed,
   input  logic [DATA_W-1:0]  div_opa,
   input  logic [DATA_W-1:0]  div_opb,
   output logic               stallreq_for_ex,
   output logic               div_ready,
   output logic [DATA_W-1:0]  div_quotient,
   output logic [DATA_W-1:0]  div_remainder
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*DATA_W:0]   r_part;
   logic [DATA_W-1:0]   r_divisor, r_opa_raw, r_quot, r_rem;
   logic                r_q_neg, r_r_neg, r_div_zero;

   logic                w_a_neg, w_b_neg, w_last, w_ge;
   logic [DATA_W-1:0]   w_a_abs, w_b_abs, w_q_mag, w_r_mag, w_q_fix, w_r_fix;
   logic [DATA_W+1:0]   w_hi;
   logic [DATA_W:0]     w_sub;
   logic [2*DATA_W:0]   w_part_nxt;
   logic                w_unused_stall;

   assign w_unused_stall = ^stall;

   assign w_a_neg = div_signed & div_opa[DATA_W-1];
   assign w_b_neg = div_signed & div_opb[DATA_W-1];
   assign w_a_abs = w_a_neg ? -div_opa : div_opa;
   assign w_b_abs = w_b_neg ? -div_opb : div_opb;

   // Shifted partial remainder includes the incoming dividend bit; the low half shifts in quotient bits.
   assign w_hi       = r_part[2*DATA_W:DATA_W-1];
   assign w_ge       = (w_hi >= {2'b00, r_divisor});
   assign w_sub      = w_hi[DATA_W:0] - {1'b0, r_divisor};
   assign w_part_nxt = {(w_ge ? w_sub : w_hi[DATA_W:0]), r_part[DATA_W-2:0], w_ge};
   assign w_last     = (r_cnt == CNT_W'(DATA_W-1));

   assign w_q_mag = w_part_nxt[DATA_W-1:0];
   assign w_r_mag = w_part_nxt[2*DATA_W-1:DATA_W];
   assign w_q_fix = r_div_zero ? '1        : (r_q_neg ? -w_q_mag : w_q_mag);
   assign w_r_fix = r_div_zero ? r_opa_raw : (r_r_neg ? -w_r_mag : w_r_mag);

`ifdef DIV_EARLY_OUT_EN
   logic w_early;
   assign w_early = (div_opb == '0) || (w_a_abs < w_b_abs);
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      stallreq_for_ex = 1'b0;
      case (r_state)
         S_IDLE: begin
            stallreq_for_ex = div_start;
            if (div_start) begin
`ifdef DIV_EARLY_OUT_EN
               w_state_nxt = w_early ? S_DONE : S_BUSY;
`else
               w_state_nxt = S_BUSY;
`endif
            end
         end
         S_BUSY: begin
            stallreq_for_ex = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (!stall[EX_STALL_BIT]) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_part     <= '0;
         r_divisor  <= '0;
         r_opa_raw  <= '0;
         r_q_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
         r_div_zero <= 1'b0;
         r_quot     <= '0;
         r_rem      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (div_start) begin
                  r_cnt      <= '0;
                  r_part     <= {{(DATA_W+1){1'b0}}, w_a_abs};
                  r_divisor  <= w_b_abs;
                  r_opa_raw  <= div_opa;
                  r_q_neg    <= w_a_neg ^ w_b_neg;
                  r_r_neg    <= w_a_neg;
                  r_div_zero <= (div_opb == '0);
`ifdef DIV_EARLY_OUT_EN
                  if (w_early) begin
                     r_quot <= (div_opb == '0) ? '1 : '0;
                     r_rem  <= div_opa;
                  end
`endif
               end
            end
            S_BUSY: begin
               r_part <= w_part_nxt;
               r_cnt  <= r_cnt + 1'b1;
               if (w_last) begin
                  r_quot <= w_q_fix;
                  r_rem  <= w_r_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_ready     = (r_state == S_DONE);
   assign div_quotient  = r_quot;
   assign div_remainder = r_rem;

endmodule

// File: tb/tb_ex_div_stall_unit.sv
// Scoreboard bench for ex_div_stall_unit: expected quotient/remainder/stall length queued at issue.
module tb_ex_div_stall_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        div_start, div_signed;
   logic [31:0] div_opa, div_opb;
   logic        stallreq_for_ex, div_ready;
   logic [31:0] div_quotient, div_remainder;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          stalls;
   } exp_t;

   exp_t sb_q[$];

   ex_div_stall_unit #(.DATA_W(32), .STALL_W(6), .EX_STALL_BIT(3)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .div_start(div_start), .div_signed(div_signed),
      .div_opa(div_opa), .div_opb(div_opb),
      .stallreq_for_ex(stallreq_for_ex), .div_ready(div_ready),
      .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         e.q = 32'hFFFFFFFF; e.r = a;
      end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         e.q = 32'h80000000; e.r = 32'd0;
      end else if (s) begin
         e.q = sa / sb; e.r = sa % sb;
      end else begin
         e.q = a / b; e.r = a % b;
      end
      e.stalls = 33;
`ifdef DIV_EARLY_OUT_EN
      begin
         logic [31:0] ma, mb;
         ma = (s && a[31]) ? -a : a;
         mb = (s && b[31]) ? -b : b;
         if (b == 32'd0 || ma < mb) e.stalls = 1;
      end
`endif
      return e;
   endfunction

   // Issues one division, pushes its expectation, returns at the first cycle div_ready is seen.
   task automatic issue_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic hold, output int nstall, output logic tmo);
      sb_q.push_back(model(s, a, b));
      nstall = 0;
      tmo    = 1'b1;
      @(negedge clk);
      div_signed = s; div_opa = a; div_opb = b; div_start = 1'b1;
      #1 if (stallreq_for_ex) nstall++;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!hold) div_start = 1'b0;
         div_opa = $urandom; div_opb = $urandom;
         #1;
         if (div_ready) begin tmo = 1'b0; break; end
         if (stallreq_for_ex) nstall++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; stall = '0; div_start = 1'b0; div_signed = 1'b0; div_opa = '0; div_opb = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL reset_stallreq got=%b exp=0", stallreq_for_ex); end
      if (div_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", div_ready); end
      if (div_quotient !== 32'd0) begin failures++; $display("FAIL reset_q got=%h exp=0", div_quotient); end
      if (div_remainder !== 32'd0) begin failures++; $display("FAIL reset_r got=%h exp=0", div_remainder); end
      rst = 1'b0;
   endtask

   task automatic test_divu_basic;
      int n; logic tmo; exp_t e;
      issue_div(1'b0, 32'd100, 32'd7, 1'b0, n, tmo);
      e = sb_q.pop_front();
      checks += 5;
      if (tmo) begin failures++; $display("FAIL divu_timeout got=no_ready exp=ready"); end
      if (div_quotient !== e.q || e.q !== 32'd14) begin failures++; $display("FAIL divu_q got=%h exp=%h", div_quotient, e.q); end
      if (div_remainder !== e.r || e.r !== 32'd2) begin failures++; $display("FAIL divu_r got=%h exp=%h", div_remainder, e.r); end
      if (n !== e.stalls) begin failures++; $display("FAIL divu_stalls got=%0d exp=%0d", n, e.stalls); end
      if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL divu_done_stallreq got=%b exp=0", stallreq_for_ex); end
      @(negedge clk); #1;
      checks++;
      if (div_ready !== 1'b0) begin failures++; $display("FAIL divu_ready_pulse got=%b exp=0", div_ready); end
   endtask

   task automatic test_arith_table(input string tag, input logic [31:0] ta[], input logic [31:0] tb[],
                                   input logic ts[]);
      int n; logic tmo; exp_t e;
      for (int k = 0; k < ta.size(); k++) begin
         issue_div(ts[k], ta[k], tb[k], 1'b0, n, tmo);
         e = sb_q.pop_front();
         checks += 4;
         if (tmo) begin failures++; $display("FAIL %s_timeout[%0d] got=no_ready exp=ready", tag, k); end
         if (div_quotient !== e.q) begin failures++; $display("FAIL %s_q[%0d] a=%h b=%h got=%h exp=%h", tag, k, ta[k], tb[k], div_quotient, e.q); end
         if (div_remainder !== e.r) begin failures++; $display("FAIL %s_r[%0d] a=%h b=%h got=%h exp=%h", tag, k, ta[k], tb[k], div_remainder, e.r); end
         if (n !== e.stalls) begin failures++; $display("FAIL %s_stalls[%0d] got=%0d exp=%0d", tag, k, n, e.stalls); end
         @(negedge clk);
      end
   endtask

   task automatic test_signed;
      logic [31:0] a[] = '{32'hFFFFFFF9, 32'd7, 32'hFFFF0000, 32'd123456789};
      logic [31:0] b[] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFF3, 32'd1000};
      logic        s[] = '{1'b1, 1'b1, 1'b1, 1'b1};
      test_arith_table("signed", a, b, s);
   endtask

   task automatic test_special;
      logic [31:0] a[] = '{32'd5, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
      logic [31:0] b[] = '{32'd0, 32'hFFFFFFFF, 32'd0, 32'd1};
      logic        s[] = '{1'b0, 1'b1, 1'b1, 1'b0};
      test_arith_table("special", a, b, s);
   endtask

   task automatic test_random;
      logic [31:0] a[] = new[6];
      logic [31:0] b[] = new[6];
      logic        s[] = new[6];
      for (int k = 0; k < 6; k++) begin
         a[k] = $urandom; b[k] = $urandom >> (k * 5); s[k] = k[0];
      end
      test_arith_table("random", a, b, s);
   endtask

   task automatic test_reset_mid;
      int n; logic tmo; exp_t e;
      @(negedge clk);
      div_signed = 1'b0; div_opa = 32'd1000; div_opb = 32'd3; div_start = 1'b1;
      @(posedge clk);
      @(negedge clk) div_start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (stallreq_for_ex !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", stallreq_for_ex); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      checks += 4;
      if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL midrst_stallreq got=%b exp=0", stallreq_for_ex); end
      if (div_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", div_ready); end
      if (div_quotient !== 32'd0) begin failures++; $display("FAIL midrst_q got=%h exp=0", div_quotient); end
      if (div_remainder !== 32'd0) begin failures++; $display("FAIL midrst_r got=%h exp=0", div_remainder); end
      issue_div(1'b0, 32'd1000, 32'd3, 1'b0, n, tmo);
      e = sb_q.pop_front();
      checks += 3;
      if (tmo) begin failures++; $display("FAIL midrst_timeout got=no_ready exp=ready"); end
      if (div_quotient !== e.q) begin failures++; $display("FAIL midrst_new_q got=%h exp=%h", div_quotient, e.q); end
      if (div_remainder !== e.r) begin failures++; $display("FAIL midrst_new_r got=%h exp=%h", div_remainder, e.r); end
      @(negedge clk);
   endtask

   task automatic test_stall_hold;
      int n; logic tmo; exp_t e;
      issue_div(1'b0, 32'd50, 32'd6, 1'b1, n, tmo);
      e = sb_q.pop_front();
      stall = 6'b001000;
      checks += 4;
      if (tmo) begin failures++; $display("FAIL hold_timeout got=no_ready exp=ready"); end
      if (div_quotient !== e.q) begin failures++; $display("FAIL hold_q got=%h exp=%h", div_quotient, e.q); end
      if (div_remainder !== e.r) begin failures++; $display("FAIL hold_r got=%h exp=%h", div_remainder, e.r); end
      if (n !== e.stalls) begin failures++; $display("FAIL hold_stalls got=%0d exp=%0d", n, e.stalls); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         checks += 4;
         if (div_ready !== 1'b1) begin failures++; $display("FAIL hold_ready[%0d] got=%b exp=1", k, div_ready); end
         if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL hold_stallreq[%0d] got=%b exp=0", k, stallreq_for_ex); end
         if (div_quotient !== e.q) begin failures++; $display("FAIL hold_q[%0d] got=%h exp=%h", k, div_quotient, e.q); end
         if (div_remainder !== e.r) begin failures++; $display("FAIL hold_r[%0d] got=%h exp=%h", k, div_remainder, e.r); end
      end
      stall = '0; div_start = 1'b0;
      @(negedge clk); #1;
      checks += 3;
      if (div_ready !== 1'b0) begin failures++; $display("FAIL hold_release_ready got=%b exp=0", div_ready); end
      if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL hold_release_stallreq got=%b exp=0", stallreq_for_ex); end
      if (div_quotient !== e.q) begin failures++; $display("FAIL hold_release_q got=%h exp=%h", div_quotient, e.q); end
   endtask

   task automatic test_small_dividend;
      int n; logic tmo; exp_t e;
      issue_div(1'b0, 32'd3, 32'd9, 1'b0, n, tmo);
      e = sb_q.pop_front();
      checks += 4;
      if (tmo) begin failures++; $display("FAIL small_timeout got=no_ready exp=ready"); end
      if (div_quotient !== e.q || e.q !== 32'd0) begin failures++; $display("FAIL small_q got=%h exp=%h", div_quotient, e.q); end
      if (div_remainder !== e.r || e.r !== 32'd3) begin failures++; $display("FAIL small_r got=%h exp=%h", div_remainder, e.r); end
      if (n !== e.stalls) begin failures++; $display("FAIL small_stalls got=%0d exp=%0d", n, e.stalls); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_special();
      test_random();
      test_reset_mid();
      test_stall_hold();
      test_small_dividend();
      checks++;
      if (sb_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
